// File: rtl/enc_binder_pack_tm.sv
// Time-multiplexed binder pack: rotates LANES level HVs per beat by per-channel shift amounts.
// Latency: 1 cycle from input accept to out_valid; sustains 1 beat/cycle when out_ready=1.
// Backpressure: output register holds under !out_ready and in_ready drops until it drains.
module enc_binder_pack_tm #(
  parameter int HV_DIM  = 1024,
  parameter int NUM_CH  = 617,
  parameter int LANES   = 59,
  parameter int SHIFT_W = $clog2(HV_DIM),
  parameter logic [NUM_CH*SHIFT_W-1:0] SHIFTS = '0,
  parameter int ROT_LEFT = 1,
  localparam int NUM_GRP = (NUM_CH + LANES - 1) / LANES,
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start_encoding,
  input  logic                          en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][HV_DIM-1:0]  level_hv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0][HV_DIM-1:0]  shifted_hv,
  output logic [LANES-1:0]              out_lane_mask,
  output logic [GRP_W-1:0]              out_grp,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRP - 1);
  localparam logic [GRP_W-1:0] GRP_ONE  = GRP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                         state_q;
  logic [GRP_W-1:0]               grp_q;
  logic                           out_valid_q;
  logic [LANES-1:0][HV_DIM-1:0]   shifted_q;
  logic [LANES-1:0]               mask_q;
  logic [GRP_W-1:0]               out_grp_q;
  logic                           out_last_q;
  logic                           done_q;

  logic                           in_fire;
  logic                           out_fire;
  logic [LANES-1:0][HV_DIM-1:0]   bind_hv_d;
  logic [LANES-1:0]               bind_mask_d;

  // Per-group, per-lane shift amount and "real channel" flag, resolved at elaboration
  // so the padding lanes of the last group never index past the SHIFTS vector.
  logic [SHIFT_W-1:0]             shift_tab [NUM_GRP][LANES];
  logic [LANES-1:0]               real_tab  [NUM_GRP];

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (g * LANES + l < NUM_CH) begin : g_real
        assign shift_tab[g][l] = SHIFTS[(g*LANES+l)*SHIFT_W +: SHIFT_W];
        assign real_tab[g][l]  = 1'b1;
      end else begin : g_pad
        assign shift_tab[g][l] = '0;
        assign real_tab[g][l]  = 1'b0;
      end
    end
  end

  // Circular rotation via a doubled vector: the slice picks up the wrapped bits.
  function automatic logic [HV_DIM-1:0] rotate_hv(input logic [HV_DIM-1:0] x,
                                                  input logic [SHIFT_W-1:0] s);
    logic [2*HV_DIM-1:0] dbl;
    if (ROT_LEFT != 0) begin
      dbl = {x, x} << s;
      return dbl[2*HV_DIM-1:HV_DIM];
    end else begin
      dbl = {x, x} >> s;
      return dbl[HV_DIM-1:0];
    end
  endfunction

  assign in_ready = (state_q == S_RUN) && en && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Bind the current group: rotate real lanes, zero the padding lanes.
  always_comb begin
    bind_hv_d   = '0;
    bind_mask_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (real_tab[grp_q][l]) begin
        bind_hv_d[l]   = rotate_hv(level_hv[l], shift_tab[grp_q][l]);
        bind_mask_d[l] = 1'b1;
      end
    end
  end

  // Pass sequencer and output register; grp_q is state so stalls never skip a group.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q     <= S_IDLE;
      grp_q       <= '0;
      out_valid_q <= 1'b0;
      shifted_q   <= '0;
      mask_q      <= '0;
      out_grp_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      // A same-cycle accept overrides the consume above, giving 1 beat/cycle.
      if (in_fire) begin
        out_valid_q <= 1'b1;
        shifted_q   <= bind_hv_d;
        mask_q      <= bind_mask_d;
        out_grp_q   <= grp_q;
        out_last_q  <= (grp_q == LAST_GRP);
      end
      case (state_q)
        S_IDLE: begin
          if (start_encoding && en) begin
            state_q <= S_RUN;
            grp_q   <= '0;
          end
        end
        S_RUN: begin
          if (in_fire) begin
            if (grp_q == LAST_GRP) begin
              state_q <= S_DRAIN;
              grp_q   <= '0;
            end else begin
              grp_q <= grp_q + GRP_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign shifted_hv    = shifted_q;
  assign out_lane_mask = mask_q;
  assign out_grp       = out_grp_q;
  assign out_last      = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_enc_binder_pack_tm.sv
// Bench for enc_binder_pack_tm: left- and right-rotating instances share one stimulus stream.
// A negedge monitor pushes expected beats on accept and pops/compares them on consume.
module tb_enc_binder_pack_tm;

  localparam int HV  = 16;
  localparam int NCH = 5;
  localparam int LN  = 2;
  localparam int NG  = 3;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic start_encoding = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [LN-1:0][HV-1:0] level_hv = '0;

  logic                  in_ready, out_valid, out_last, busy, done;
  logic [LN-1:0][HV-1:0] shifted_hv;
  logic [LN-1:0]         out_lane_mask;
  logic [1:0]            out_grp;

  logic                  in_ready_r, out_valid_r, out_last_r, busy_r, done_r;
  logic [LN-1:0][HV-1:0] shifted_hv_r;
  logic [LN-1:0]         out_lane_mask_r;
  logic [1:0]            out_grp_r;

  enc_binder_pack_tm #(.HV_DIM(HV), .NUM_CH(NCH), .LANES(LN), .SHIFT_W(4),
                       .SHIFTS(20'h8F310), .ROT_LEFT(1)) dut (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .level_hv(level_hv),
    .out_valid(out_valid), .out_ready(out_ready), .shifted_hv(shifted_hv),
    .out_lane_mask(out_lane_mask), .out_grp(out_grp), .out_last(out_last),
    .busy(busy), .done(done));

  enc_binder_pack_tm #(.HV_DIM(HV), .NUM_CH(NCH), .LANES(LN), .SHIFT_W(4),
                       .SHIFTS(20'h8F310), .ROT_LEFT(0)) dut_r (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .en(en),
    .in_valid(in_valid), .in_ready(in_ready_r), .level_hv(level_hv),
    .out_valid(out_valid_r), .out_ready(out_ready), .shifted_hv(shifted_hv_r),
    .out_lane_mask(out_lane_mask_r), .out_grp(out_grp_r), .out_last(out_last_r),
    .busy(busy_r), .done(done_r));

  always #5 clk = ~clk;

  typedef struct {
    logic [LN-1:0][HV-1:0] hv_l;
    logic [LN-1:0][HV-1:0] hv_r;
    logic [LN-1:0]         mask;
    logic [1:0]            grp;
    logic                  last;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   out_cnt  = 0;
  int   done_cnt = 0;
  int   tb_grp   = 0;
  bit   tb_busy  = 0;
  bit   pend_done = 0;
  int   sh_tab[NCH] = '{0, 1, 3, 15, 8};
  logic [LN-1:0][HV-1:0] cap_hv [8];
  logic [LN-1:0][HV-1:0] cap_hv_r [8];
  time  cap_t [8];

  // Bit-by-bit rotation model: bit i moves to (i+s)%HV when left, (i-s)%HV when right.
  function automatic logic [HV-1:0] rot_model(input logic [HV-1:0] x, input int s, input bit left);
    logic [HV-1:0] r;
    r = '0;
    for (int i = 0; i < HV; i++) begin
      if (x[i]) begin
        if (left) r[(i + s) % HV] = 1'b1;
        else      r[(i - s + HV) % HV] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst) begin
        sb.delete();
        tb_grp = 0;
        tb_busy = 0;
        pend_done = 0;
      end else begin
        chk_cnt++;
        if (busy === tb_busy) pass_cnt++;
        else $display("FAIL busy_track: busy=%b expected=%b at %0t", busy, tb_busy, $time);
        if (pend_done || done === 1'b1) begin
          chk_cnt++;
          if (done === 1'b1 && pend_done) pass_cnt++;
          else $display("FAIL done_pulse: done=%b expected=%b at %0t", done, pend_done, $time);
        end
        if (done === 1'b1) done_cnt++;
        pend_done = 0;
        if (out_valid === 1'b1 && out_ready) begin
          chk_cnt++;
          if (sb.size() == 0) begin
            $display("FAIL sb_underflow: unexpected beat hv=%h at %0t", shifted_hv, $time);
          end else begin
            e = sb.pop_front();
            if (shifted_hv === e.hv_l && out_lane_mask === e.mask && out_grp === e.grp &&
                out_last === e.last && out_valid_r === 1'b1 && shifted_hv_r === e.hv_r)
              pass_cnt++;
            else
              $display("FAIL beat: got hv=%h mask=%b grp=%0d last=%b hv_r=%h, expected hv=%h mask=%b grp=%0d last=%b hv_r=%h",
                       shifted_hv, out_lane_mask, out_grp, out_last, shifted_hv_r,
                       e.hv_l, e.mask, e.grp, e.last, e.hv_r);
          end
          cap_hv[out_cnt % 8]   = shifted_hv;
          cap_hv_r[out_cnt % 8] = shifted_hv_r;
          cap_t[out_cnt % 8]    = $time;
          out_cnt++;
          if (out_last === 1'b1) begin
            pend_done = 1;
            tb_busy = 0;
          end
        end
        if (start_encoding && en && !tb_busy) begin
          tb_busy = 1;
          tb_grp = 0;
        end
        if (in_valid && in_ready === 1'b1) begin
          e.hv_l = '0;
          e.hv_r = '0;
          e.mask = '0;
          e.grp  = 2'(tb_grp);
          e.last = (tb_grp == NG - 1);
          for (int l = 0; l < LN; l++) begin
            if (tb_grp * LN + l < NCH) begin
              e.hv_l[l] = rot_model(level_hv[l], sh_tab[tb_grp*LN+l], 1'b1);
              e.hv_r[l] = rot_model(level_hv[l], sh_tab[tb_grp*LN+l], 1'b0);
              e.mask[l] = 1'b1;
            end
          end
          sb.push_back(e);
          tb_grp = (tb_grp + 1) % NG;
        end
      end
    end
  endtask

  task automatic start_pass();
    @(posedge clk); #1;
    start_encoding = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    start_encoding = 1'b0;
  endtask

  task automatic send_beat(input logic [HV-1:0] a, input logic [HV-1:0] b, input string nm);
    bit got;
    got = 0;
    in_valid = 1'b1;
    level_hv[0] = a;
    level_hv[1] = b;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (got) pass_cnt++;
    else $display("FAIL %s_accept: in_ready stayed low for 64 cycles", nm);
  endtask

  task automatic wait_done(input string nm);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 64 && done_cnt == d0; k++) begin
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (done_cnt > d0) pass_cnt++;
    else $display("FAIL %s_done: no done pulse within 64 cycles", nm);
  endtask

  task automatic check_count(input int base, input int want, input string nm);
    chk_cnt++;
    if (out_cnt - base === want) pass_cnt++;
    else $display("FAIL %s_count: beats=%0d expected=%0d", nm, out_cnt - base, want);
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if (out_valid === 1'b0 && in_ready === 1'b0 && busy === 1'b0 && done === 1'b0) pass_cnt++;
    else $display("FAIL reset_ctrl: out_valid=%b in_ready=%b busy=%b done=%b expected all 0",
                  out_valid, in_ready, busy, done);
    chk_cnt++;
    if (shifted_hv === '0 && out_lane_mask === '0 && out_grp === 2'd0 && out_last === 1'b0) pass_cnt++;
    else $display("FAIL reset_data: hv=%h mask=%b grp=%0d last=%b expected all 0",
                  shifted_hv, out_lane_mask, out_grp, out_last);
    @(posedge clk); #1;
    nrst = 1'b0;
  endtask

  task automatic test_basic();
    int b;
    logic [LN-1:0][HV-1:0] exp_b [3];
    logic [LN-1:0][HV-1:0] got_r;
    exp_b[0] = {16'h0002, 16'h0001};
    exp_b[1] = {16'h8000, 16'h0008};
    exp_b[2] = {16'h0000, 16'h0100};
    out_ready = 1'b1;
    b = out_cnt;
    start_pass();
    for (int k = 0; k < NG; k++) send_beat(16'h0001, 16'h0001, "basic");
    wait_done("basic");
    check_count(b, 3, "basic");
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (cap_hv[(b + k) % 8] === exp_b[k]) pass_cnt++;
      else $display("FAIL basic_beat%0d: hv=%h expected=%h", k, cap_hv[(b + k) % 8], exp_b[k]);
    end
    chk_cnt++;
    if (cap_t[(b + 1) % 8] - cap_t[b % 8] === 10 && cap_t[(b + 2) % 8] - cap_t[(b + 1) % 8] === 10) pass_cnt++;
    else $display("FAIL back_to_back: beat spacing %0t/%0t expected 10/10",
                  cap_t[(b + 1) % 8] - cap_t[b % 8], cap_t[(b + 2) % 8] - cap_t[(b + 1) % 8]);
    got_r = cap_hv_r[b % 8];
    chk_cnt++;
    if (got_r[1] === 16'h8000) pass_cnt++;
    else $display("FAIL rot_right_wrap: hv=%h expected=8000", got_r[1]);
  endtask

  task automatic test_backpressure();
    int b;
    logic [LN-1:0][HV-1:0] held;
    out_ready = 1'b1;
    b = out_cnt;
    start_pass();
    send_beat(16'h1234, 16'h00F0, "bp0");
    out_ready = 1'b0;
    in_valid = 1'b1;
    level_hv = {16'hA5A5, 16'h0F0F};
    held = shifted_hv;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready === 1'b0 && out_valid === 1'b1 && shifted_hv === held) pass_cnt++;
      else $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b hv=%h expected 0/1/%h",
                    k, in_ready, out_valid, shifted_hv, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(16'h0F0F, 16'hA5A5, "bp1");
    send_beat(16'hFFFF, 16'h7777, "bp2");
    wait_done("bp");
    check_count(b, 3, "bp");
  endtask

  task automatic test_wrap();
    int b;
    logic [LN-1:0][HV-1:0] g;
    out_ready = 1'b1;
    b = out_cnt;
    start_pass();
    for (int k = 0; k < NG; k++) send_beat(16'h8001, 16'h8001, "wrap");
    wait_done("wrap");
    g = cap_hv[(b + 1) % 8];
    chk_cnt++;
    if (g[1] === 16'hC000 && g[0] === 16'h000C) pass_cnt++;
    else $display("FAIL wrap_shift15: lanes=%h/%h expected C000/000C", g[1], g[0]);
  endtask

  task automatic test_en_drop();
    int b;
    out_ready = 1'b1;
    b = out_cnt;
    start_pass();
    send_beat(16'h0003, 16'h0005, "en0");
    en = 1'b0;
    in_valid = 1'b1;
    level_hv = {16'h0300, 16'h0030};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready === 1'b0) pass_cnt++;
      else $display("FAIL en_drop%0d: in_ready=%b expected 0", k, in_ready);
      @(posedge clk); #1;
    end
    en = 1'b1;
    send_beat(16'h0030, 16'h0300, "en1");
    send_beat(16'h4001, 16'h1234, "en2");
    wait_done("en");
    check_count(b, 3, "en");
  endtask

  task automatic test_reset_mid();
    int b, d0;
    out_ready = 1'b1;
    start_pass();
    send_beat(16'h00FF, 16'hFF00, "rst0");
    nrst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid === 1'b0 && in_ready === 1'b0 && shifted_hv === '0 && out_lane_mask === '0 &&
        out_grp === 2'd0 && out_last === 1'b0 && done === 1'b0) pass_cnt++;
    else $display("FAIL midrst_out: out_valid=%b in_ready=%b hv=%h mask=%b grp=%0d last=%b done=%b expected all 0",
                  out_valid, in_ready, shifted_hv, out_lane_mask, out_grp, out_last, done);
    chk_cnt++;
    if (busy === 1'b0) pass_cnt++;
    else $display("FAIL midrst_busy: busy=%b expected 0", busy);
    @(posedge clk); #1;
    nrst = 1'b0;
    d0 = done_cnt;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (done_cnt === d0) pass_cnt++;
    else $display("FAIL midrst_nodone: done pulses=%0d expected 0", done_cnt - d0);
    b = out_cnt;
    start_pass();
    for (int k = 0; k < NG; k++) send_beat(16'h0101, 16'h1010, "rst1");
    wait_done("rst1");
    check_count(b, 3, "rst1");
  endtask

  task automatic test_start_ignored();
    int b;
    out_ready = 1'b1;
    b = out_cnt;
    start_pass();
    send_beat(16'h0011, 16'h0022, "st0");
    start_encoding = 1'b1;
    send_beat(16'h0033, 16'h0044, "st1");
    start_encoding = 1'b0;
    send_beat(16'h0055, 16'h0066, "st2");
    out_ready = 1'b0;
    start_encoding = 1'b1;
    @(posedge clk); #1;
    start_encoding = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("st");
    check_count(b, 3, "st");
    @(posedge clk); #1;
    chk_cnt++;
    if (busy === 1'b0) pass_cnt++;
    else $display("FAIL st_idle: busy=%b expected 0", busy);
    en = 1'b0;
    start_encoding = 1'b1;
    @(posedge clk); #1;
    start_encoding = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy === 1'b0) pass_cnt++;
    else $display("FAIL st_en0: busy=%b expected 0", busy);
    en = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_en_drop();
    test_reset_mid();
    test_start_ignored();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
